// File: rtl/lelo_temp_mcnt.sv
// lelo_temp_mcnt: multi-channel temperature-oscillator edge counter.
// Powers one oscillator at a time, lets it settle, counts synchronized rising
// edges over a programmable window, then presents the result on a
// valid/ready handshake before moving to the next enabled channel.
// Optional build macro: LELO_TEMP_AVG_EN (four windows per channel, averaged).
module lelo_temp_mcnt #(
    parameter int NCH    = 4,
    parameter int CW     = 16,
    parameter int WINW   = 16,
    parameter int SETTLE = 16,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               CLK_1V8,
    input  logic               RST_1V8,
    input  logic               START,
    input  logic [NCH-1:0]     CH_EN,
    input  logic [WINW-1:0]    WIN_LEN,
    input  logic [NCH-1:0]     OSC_TEMP_1V8,
    output logic [NCH-1:0]     PWRUP_1V8,
    output logic               BUSY,
    output logic [CW-1:0]      DATA,
    output logic [CHW-1:0]     DATA_CH,
    output logic               DATA_OVF,
    output logic               DATA_VALID,
    input  logic               DATA_READY
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_HOLD} state_t;

    state_t          state;
    logic [NCH-1:0]  en_mask;
    logic [WINW-1:0] win_len;
    logic [CHW-1:0]  ch;
    logic [SW-1:0]   settle_cnt;
    logic [WINW-1:0] win_cnt;
    logic [CW-1:0]   count;
    logic            cnt_ovf;
    logic [1:0]      sync;
    logic            sync_prev;
    logic [NCH-1:0]  pwr;
    logic            busy_st;
    logic [CW-1:0]   result;
    logic [CHW-1:0]  result_ch;
    logic            result_ovf;
    logic            result_vld;

    logic            osc_sel;
    logic            rise;
    logic [CW:0]     cnt_nxt;
    logic [WINW-1:0] win_load;
    logic [CHW:0]    first_sel;
    logic [CHW:0]    next_sel;

    // Saturating increment; MSB of the return value flags a lost edge.
    function automatic logic [CW:0] sat_inc(input logic [CW-1:0] v, input logic inc);
        if (inc && (&v))
            return {1'b1, v};
        return {1'b0, v + CW'(inc)};
    endfunction

    // Lowest enabled channel with index >= from; MSB is the found flag.
    function automatic logic [CHW:0] find_en(input logic [NCH-1:0] m, input int from);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (i >= from && m[i])
                r = {1'b1, CHW'(i)};
        return r;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] idx);
        return NCH'(1) << idx;
    endfunction

`ifdef LELO_TEMP_AVG_EN
    localparam int AW = CW + 2;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [1:0]    widx;

    // Saturating accumulate of one window count.
    function automatic logic [AW-1:0] sat_acc(input logic [AW-1:0] a, input logic [CW-1:0] v);
        logic [AW:0] s;
        s = {1'b0, a} + {{(AW + 1 - CW){1'b0}}, v};
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
    endfunction
`endif

    // Active-channel select, edge detect, next-count and channel search.
    always_comb begin
        osc_sel   = OSC_TEMP_1V8[ch];
        rise      = sync[1] & ~sync_prev;
        cnt_nxt   = sat_inc(count, rise);
        win_load  = (win_len == '0) ? '0 : win_len - WINW'(1);
        first_sel = find_en(CH_EN, 0);
        next_sel  = find_en(en_mask, int'(ch) + 1);
`ifdef LELO_TEMP_AVG_EN
        acc_nxt   = sat_acc(acc, cnt_nxt[CW-1:0]);
`endif
    end

    // Scan FSM with registered power, busy and result outputs.
    always_ff @(posedge CLK_1V8 or posedge RST_1V8) begin
        if (RST_1V8) begin
            state      <= ST_IDLE;
            en_mask    <= '0;
            win_len    <= '0;
            ch         <= '0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            count      <= '0;
            cnt_ovf    <= 1'b0;
            sync       <= '0;
            sync_prev  <= 1'b0;
            pwr        <= '0;
            busy_st    <= 1'b0;
            result     <= '0;
            result_ch  <= '0;
            result_ovf <= 1'b0;
            result_vld <= 1'b0;
`ifdef LELO_TEMP_AVG_EN
            acc        <= '0;
            widx       <= '0;
`endif
        end else begin
            sync      <= {sync[0], osc_sel};
            sync_prev <= sync[1];
            case (state)
                ST_IDLE: begin
                    if (START && (CH_EN != '0)) begin
                        en_mask    <= CH_EN;
                        win_len    <= WIN_LEN;
                        ch         <= first_sel[CHW-1:0];
                        pwr        <= onehot(first_sel[CHW-1:0]);
                        busy_st    <= 1'b1;
                        settle_cnt <= SW'(SETTLE - 1);
                        sync       <= '0;
                        sync_prev  <= 1'b0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        win_cnt <= win_load;
                        count   <= '0;
                        cnt_ovf <= 1'b0;
`ifdef LELO_TEMP_AVG_EN
                        acc     <= '0;
                        widx    <= '0;
`endif
                        state   <= ST_COUNT;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                ST_COUNT: begin
                    if (win_cnt != '0) begin
                        win_cnt <= win_cnt - WINW'(1);
                        count   <= cnt_nxt[CW-1:0];
                        cnt_ovf <= cnt_ovf | cnt_nxt[CW];
                    end else begin
`ifdef LELO_TEMP_AVG_EN
                        if (widx != 2'd3) begin
                            widx    <= widx + 2'd1;
                            acc     <= acc_nxt;
                            win_cnt <= win_load;
                            count   <= '0;
                            cnt_ovf <= cnt_ovf | cnt_nxt[CW];
                        end else begin
                            result     <= acc_nxt[AW-1:2];
                            result_ovf <= cnt_ovf | cnt_nxt[CW];
                            result_ch  <= ch;
                            result_vld <= 1'b1;
                            pwr        <= '0;
                            state      <= ST_HOLD;
                        end
`else
                        result     <= cnt_nxt[CW-1:0];
                        result_ovf <= cnt_ovf | cnt_nxt[CW];
                        result_ch  <= ch;
                        result_vld <= 1'b1;
                        pwr        <= '0;
                        state      <= ST_HOLD;
`endif
                    end
                end
                ST_HOLD: begin
                    if (DATA_READY) begin
                        result_vld <= 1'b0;
                        if (next_sel[CHW]) begin
                            ch         <= next_sel[CHW-1:0];
                            pwr        <= onehot(next_sel[CHW-1:0]);
                            settle_cnt <= SW'(SETTLE - 1);
                            sync       <= '0;
                            sync_prev  <= 1'b0;
                            state      <= ST_SETTLE;
                        end else begin
                            busy_st <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign PWRUP_1V8  = pwr;
    assign BUSY       = busy_st;
    assign DATA       = result;
    assign DATA_CH    = result_ch;
    assign DATA_OVF   = result_ovf;
    assign DATA_VALID = result_vld;

endmodule

// File: tb/tb_lelo_temp_mcnt.sv
// Directed bench for lelo_temp_mcnt (default build). A second instance with
// CW=4 shares all inputs to exercise count saturation.
module tb_lelo_temp_mcnt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [3:0]  ch_en;
    logic [15:0] win_len;
    logic [3:0]  osc = '0;

    logic [3:0]  pwrup, pwrup4;
    logic        busy, busy4;
    logic [15:0] data;
    logic [3:0]  data4;
    logic [1:0]  data_ch, data_ch4;
    logic        data_ovf, ovf4;
    logic        data_valid, valid4;

    lelo_temp_mcnt dut (
        .CLK_1V8(clk), .RST_1V8(rst), .START(start), .CH_EN(ch_en),
        .WIN_LEN(win_len), .OSC_TEMP_1V8(osc), .PWRUP_1V8(pwrup), .BUSY(busy),
        .DATA(data), .DATA_CH(data_ch), .DATA_OVF(data_ovf),
        .DATA_VALID(data_valid), .DATA_READY(ready)
    );

    lelo_temp_mcnt #(.CW(4)) dut4 (
        .CLK_1V8(clk), .RST_1V8(rst), .START(start), .CH_EN(ch_en),
        .WIN_LEN(win_len), .OSC_TEMP_1V8(osc), .PWRUP_1V8(pwrup4), .BUSY(busy4),
        .DATA(data4), .DATA_CH(data_ch4), .DATA_OVF(ovf4),
        .DATA_VALID(valid4), .DATA_READY(ready)
    );

    always #5 clk = ~clk;

    // Oscillator models: period per[i] clocks (0 = stopped), edges off the clock edge.
    int per[4] = '{default: 0};
    int ph[4]  = '{default: 0};
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) begin
                ph[i] = 0;
            end else begin
                ph[i]++;
                if (ph[i] >= per[i] / 2) begin
                    ph[i]  = 0;
                    osc[i] = ~osc[i];
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_tests++;
        if (got < exp - tol || got > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    int r_data[8], r_ch[8], r_ovf[8], r_d4[8], r_o4[8], r_c4[8];
    int nres, hc, next_pw, t_xfer, t_end;
    int pcnt[4];
    bit stab_bad, pw_bad, twin_bad, tmo;

    // Run one scan from START until BUSY drops, logging results and power time.
    task automatic scan(input logic [3:0] mask, input logic [15:0] win, input int stall, input int restart_at);
        int d0, c0;
        bit chk_next;
        nres = 0; hc = 0; stab_bad = 0; pw_bad = 0; twin_bad = 0;
        next_pw = -1; t_xfer = -1; t_end = -1; tmo = 1; chk_next = 0; d0 = 0; c0 = 0;
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
        ready   = (stall == 0);
        ch_en   = mask;
        win_len = win;
        start   = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) start = 1'b0;
            if (t == restart_at) begin
                start = 1'b1;
                ch_en = 4'b1111;
            end else if (t == restart_at + 1) begin
                start = 1'b0;
            end
            for (int i = 0; i < 4; i++) pcnt[i] += int'(pwrup[i]);
            if (pwrup4 != pwrup || busy4 != busy || valid4 != data_valid) twin_bad = 1;
            if (chk_next) begin
                next_pw  = int'(pwrup);
                chk_next = 0;
            end
            if (data_valid && !ready) begin
                if (hc == 0) begin
                    d0 = int'(data);
                    c0 = int'(data_ch);
                end
                hc++;
                if (int'(data) != d0 || int'(data_ch) != c0) stab_bad = 1;
                if (pwrup != 4'b0000) pw_bad = 1;
                if (hc == stall) begin
                    ready    = 1'b1;
                    chk_next = 1;
                end
            end
            if (data_valid && ready && nres < 8) begin
                r_data[nres] = int'(data);
                r_ch[nres]   = int'(data_ch);
                r_ovf[nres]  = int'(data_ovf);
                r_d4[nres]   = int'(data4);
                r_o4[nres]   = int'(ovf4);
                r_c4[nres]   = int'(data_ch4);
                t_xfer       = t;
                nres++;
            end
            if (!busy) begin
                t_end = t;
                tmo   = 0;
                break;
            end
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        bit quiet_bad;
        rst = 1'b1; start = 1'b0; ready = 1'b1; ch_en = '0; win_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwrup", pwrup, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_data_ch", data_ch, 0);
        chk("rst_ovf", data_ovf, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // START with an empty mask stays idle.
        start = 1'b1; ch_en = 4'b0000; win_len = 16'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mask0_busy", busy, 0);
        chk("mask0_pwrup", pwrup, 0);

        // Single channel, period 20, window 200.
        per[0] = 20;
        scan(4'b0001, 16'd200, 0, -1);
        chk("one_tmo", tmo, 0);
        chk("one_nres", nres, 1);
        chk("one_data", r_data[0], 10, 1);
        chk("one_ch", r_ch[0], 0);
        chk("one_ovf", r_ovf[0], 0);
        chk("one_pw0", pcnt[0], 216);
        chk("one_pw_other", pcnt[1] + pcnt[2] + pcnt[3], 0);
        chk("one_busy_fall", t_end - t_xfer, 1);

        // Two sparse channels, ordered results, others unpowered.
        per[1] = 20; per[2] = 20; per[3] = 40;
        scan(4'b1010, 16'd400, 0, -1);
        chk("two_tmo", tmo, 0);
        chk("two_nres", nres, 2);
        chk("two_ch_a", r_ch[0], 1);
        chk("two_data_a", r_data[0], 20, 1);
        chk("two_ch_b", r_ch[1], 3);
        chk("two_data_b", r_data[1], 10, 1);
        chk("two_pw0", pcnt[0], 0);
        chk("two_pw2", pcnt[2], 0);
        chk("two_pw1", pcnt[1], 416);
        chk("two_pw3", pcnt[3], 416);

        // Long window: 16-bit instance counts ~50, 4-bit instance saturates.
        scan(4'b0001, 16'd1000, 0, -1);
        chk("sat_tmo", tmo, 0);
        chk("sat_nres", nres, 1);
        chk("sat_data16", r_data[0], 50, 1);
        chk("sat_ovf16", r_ovf[0], 0);
        chk("sat_data4", r_d4[0], 15);
        chk("sat_ovf4", r_o4[0], 1);
        chk("sat_ch4", r_c4[0], 0);
        chk("sat_twin", twin_bad, 0);

        // Back-pressure: READY low for 50 cycles in HOLD.
        scan(4'b1010, 16'd100, 50, -1);
        chk("bp_tmo", tmo, 0);
        chk("bp_hold_cycles", hc, 50);
        chk("bp_stable", stab_bad, 0);
        chk("bp_no_power", pw_bad, 0);
        chk("bp_next_pw", next_pw, 8);
        chk("bp_nres", nres, 2);
        chk("bp_ch_a", r_ch[0], 1);
        chk("bp_data_a", r_data[0], 5, 1);
        chk("bp_ch_b", r_ch[1], 3);
        chk("bp_data_b", r_data[1], 2, 1);
        chk("bp_pw3", pcnt[3], 116);

        // Reset in the middle of COUNT.
        ch_en = 4'b0001; win_len = 16'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_pwrup", pwrup, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pwrup", pwrup, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", data_valid, 0);
        chk("arst_data", data, 0);
        chk("arst_data_ch", data_ch, 0);
        chk("arst_ovf", data_ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet_bad = 0;
        for (int t = 0; t < 250; t++) begin
            @(posedge clk);
            #1;
            if (data_valid || busy || pwrup != 4'b0000) quiet_bad = 1;
        end
        chk("post_rst_quiet", quiet_bad, 0);

        // WIN_LEN=0 runs a one-cycle window; START during the scan is ignored.
        scan(4'b0001, 16'd0, 0, 5);
        chk("w0_tmo", tmo, 0);
        chk("w0_nres", nres, 1);
        chk("w0_ch", r_ch[0], 0);
        chk("w0_data", r_data[0], 0, 1);
        chk("w0_pw0", pcnt[0], 17);
        chk("w0_pw_other", pcnt[1] + pcnt[2] + pcnt[3], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("w0_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lelo_temp_mcnt.md
LELO_TEMP_MCNT -- requirements
Module: lelo_temp_mcnt

Interface
REQ-001 Parameter NCH, default 4: number of temperature-oscillator channels (1..16).
REQ-002 Parameter CW, default 16: edge-count result width.
REQ-003 Parameter WINW, default 16: width of the window-length input.
REQ-004 Parameter SETTLE, default 16: oscillator settle time after power-up, in clock cycles (>=1).
REQ-005 CLK_1V8  input  1  system clock; all state on the rising edge.
REQ-006 RST_1V8  input  1  asynchronous, active-high reset.
REQ-007 START  input  1  single-cycle request to scan all enabled channels.
REQ-008 CH_EN  input  NCH  channel enable mask; latched at accepted START.
REQ-009 WIN_LEN  input  WINW  count window in clock cycles; latched at accepted START; 0 is treated as 1.
REQ-010 OSC_TEMP_1V8  input  NCH  asynchronous oscillator outputs, one per channel.
REQ-011 PWRUP_1V8  output  NCH  one-hot oscillator power-up; all zero when idle.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 DATA  output  CW  measured edge count.
REQ-014 DATA_CH  output  max(1,clog2(NCH))  channel index of DATA.
REQ-015 DATA_OVF  output  1  count saturated during the measurement.
REQ-016 DATA_VALID / DATA_READY  output / input  1 / 1  valid/ready result handshake.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, COUNT, HOLD.
REQ-018 IDLE: START=1 with CH_EN!=0 SHALL enter SETTLE next cycle on the lowest-index enabled channel. START with CH_EN=0 SHALL be ignored.
REQ-019 START outside IDLE SHALL be ignored.
REQ-020 PWRUP_1V8[ch] SHALL be high exactly in SETTLE and COUNT for the active channel, and low in all other states.
REQ-021 SETTLE SHALL last SETTLE cycles. The 2-flop synchronizer and edge detector of the active channel SHALL be cleared on SETTLE entry. COUNT follows.
REQ-022 COUNT SHALL last max(WIN_LEN,1) cycles. Each synchronized rising edge SHALL increment the count by 1.
REQ-023 The count SHALL saturate at 2^CW-1 and set DATA_OVF. It SHALL never wrap.
REQ-024 On leaving COUNT, the FSM SHALL enter HOLD with DATA, DATA_CH and DATA_OVF registered and DATA_VALID=1. These outputs SHALL stay stable until the transfer.
REQ-025 A transfer SHALL occur on a cycle with DATA_VALID&DATA_READY=1. On the following cycle:
  - DATA_VALID=0;
  - the FSM enters SETTLE for the next higher enabled channel, or IDLE if none remain.
REQ-026 DATA_READY held high SHALL give a zero-stall transfer (HOLD lasts one cycle). DATA_READY low SHALL hold HOLD indefinitely.
REQ-027 Oscillator inputs of inactive channels SHALL be ignored.

Reset
REQ-028 RST_1V8 high SHALL immediately (asynchronously) force:
  - FSM to IDLE;
  - PWRUP_1V8=0, BUSY=0, DATA_VALID=0;
  - DATA=0, DATA_CH=0, DATA_OVF=0;
  - all counters, latched CH_EN and WIN_LEN, and synchronizers to 0.
REQ-029 Reset mid-scan SHALL abandon the scan; no partial result SHALL be presented after reset release.
REQ-030 The first START accepted after reset release SHALL behave as from power-on.

Configuration
REQ-031 Macro LELO_TEMP_AVG_EN defined:
  - each channel SHALL run 4 consecutive COUNT windows with PWRUP held and no re-settle;
  - windows SHALL accumulate into a saturating CW+2-bit accumulator;
  - DATA SHALL be accumulator>>2;
  - DATA_OVF SHALL be set if any window saturated.
REQ-032 Macro LELO_TEMP_AVG_EN undefined: one COUNT window per channel; no accumulator logic SHALL be synthesized.

Verification
REQ-033 CH_EN=4'b0001, WIN_LEN=200, osc period 20 clk, READY=1 -> PWRUP_1V8=0001 for 16+200 cycles; DATA=10±1, DATA_CH=0, DATA_OVF=0; BUSY falls 1 cycle after transfer.
REQ-034 CH_EN=4'b1010, osc periods ch1=20 and ch3=40 clk, WIN_LEN=400 -> two results in order: DATA_CH=1 with DATA=20±1, then DATA_CH=3 with DATA=10±1; channels 0 and 2 never powered.
REQ-035 CW=4, WIN_LEN=1000, osc period 20 clk -> DATA=15, DATA_OVF=1.
REQ-036 DATA_READY held low for 50 cycles in HOLD -> DATA, DATA_CH and DATA_VALID stable; no channel powered; next channel starts the cycle after READY rises.
REQ-037 RST_1V8 pulsed mid-COUNT, then START with WIN_LEN=0 -> all outputs zero during reset; after release the scan runs a 1-cycle window; second START during BUSY ignored.
REQ-038 LELO_TEMP_AVG_EN defined, osc period 20 clk, WIN_LEN=200 -> PWRUP held for 16+800 cycles; DATA=10±1.
